fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the 8-entry, 12-bit instruction memory. It owns the program counter, drives the memory's read index, captures the combinationally-read instruction word and splits it into opcode/field outputs. It resolves jump and halt opcodes locally and presents every other instruction to the execute stage through a valid/ready handshake, accepting branch redirects back from execute.

## Interface
- `AW`, 3: PC / memory index width (memory depth 2**AW)
- `IW`, 12: instruction width; opcode = [IW-1:IW-3], fields a/b/c = next three 3-bit slices
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `run`  in  1  level; 1 = fetch permitted
- `imem_index`  out  AW  read address to instruction memory; equals `pc`
- `imem_data`  in  IW  instruction word read at `imem_index`, same cycle
- `br_taken`  in  1  single-cycle redirect pulse from execute
- `br_target`  in  AW  redirect address, valid with `br_taken`
- `issue_valid`  out  1  issue register holds an instruction
- `issue_ready`  in  1  execute accepts when `issue_valid && issue_ready`
- `issue_opcode`  out  3  opcode [11:9]
- `issue_a`, `issue_b`, `issue_c`  out  3 each  fields [8:6], [5:3], [2:0]
- `issue_pc`  out  AW  address the issued instruction came from
- `pc`  out  AW  next address to fetch
- `halted`  out  1  HALT state reached (sticky)

## Operation
- States: IDLE, RUN, HALT. Reset -> IDLE, `pc`=0, `issue_valid`=0, all issue fields/`issue_pc`=0, `halted`=0.
- IDLE: no fetch; `run`=1 -> RUN.
- RUN: fetch enable `fe = run && (!issue_valid || issue_ready) && !br_taken`. When `fe`:
  - opcode 3'b110 (JMP): `pc` <= field c; not issued; stay RUN.
  - opcode 3'b111 (HALT): not issued; -> HALT; `halted` <= 1; `pc` unchanged.
  - else: load issue register (opcode, a, b, c, `issue_pc` = `pc`), `issue_valid` <= 1, `pc` <= `pc`+1 mod 2**AW (7 -> 0).
  - If `fe` fires on a non-issuing opcode while the held instruction is accepted, `issue_valid` <= 0.
- Handshake: not `fe`, accept -> `issue_valid` <= 0. Held instruction: all issue outputs stable until accepted.
- `br_taken` (RUN only): `pc` <= `br_target`; issue register flushed (`issue_valid` <= 0, even if `issue_ready` the same cycle); no fetch that cycle. Priority: reset > `br_taken` > JMP/HALT > normal.
- `run` falls in RUN: no new fetch; held instruction still drains; -> IDLE once `issue_valid`=0. `pc` retained; `run`=1 resumes from `pc`.
- HALT: sticky until reset; `br_taken` and `run` ignored; held instruction (issued before HALT decoded) still drains normally.

## Timing
- `imem_index` is combinational from `pc`; memory read is combinational; decode and capture on the same edge: one instruction fetched per cycle at full throughput.
- Latency `pc` update -> `issue_valid` for that word: 1 cycle.
- Sustained rate with `issue_ready`=1: 1 issue/cycle; JMP costs one bubble; `br_taken` costs one bubble.
- IDLE -> RUN: first fetch on the first cycle in RUN (one cycle after `run` sampled high).
- Reset assertion mid-operation clears all state asynchronously; first fetch from address 0 no earlier than the second edge after release.

## Structure
- Shared package `cpu_pkg`: `OP_JMP`=3'b110, `OP_HALT`=3'b111, opcode/field bit-position constants, `fetch_state_t` enum {IDLE, RUN, HALT}; also used by execute.
- No sub-module; field split is a package function `instr_fields()` shared with execute.

## Test plan
- Reset, `run`=1, memory holds 12'b001_000_000_000 at 0..6, `issue_ready`=1 -> `issue_valid` high from cycle 2, `issue_pc` 0,1,2,... one per cycle.
- Memory[3]=12'b110_000_000_001, others ALU ops -> issued `issue_pc` 0,1,2, bubble, 1,2, bubble... (jump loop); address 3 never issued.
- `issue_ready`=0 for 4 cycles with instruction at 2 held -> all issue outputs constant, `pc`=3, no fetch; release -> 2 then 3 issued back-to-back.
- `br_taken`=1, `br_target`=5 while address 4 held unaccepted -> `issue_valid`=0 next cycle, then `issue_pc`=5; address 4 never accepted.
- Memory[7]=12'b111_000_000_000, sequential run -> 0..6 issued, `halted`=1, `pc`=7, no further issues; `br_taken` ignored; `reset` low -> `pc`=0, `halted`=0.
- `pc`=7 with ALU op at 7 -> `pc` wraps to 0; `run` dropped mid-stream -> drains held instruction, IDLE, resumes at saved `pc`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field layout and the
// fetch-stage state type. The execute stage imports this package too.
package cpu_pkg;

  localparam int INSTR_W = 12;

  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 9;
  localparam int FA_MSB  = 8;
  localparam int FA_LSB  = 6;
  localparam int FB_MSB  = 5;
  localparam int FB_LSB  = 3;
  localparam int FC_MSB  = 2;
  localparam int FC_LSB  = 0;

  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] c;
  } instr_fields_t;

  // Single definition of the word layout so fetch and execute cannot disagree.
  function automatic instr_fields_t instr_fields(input logic [INSTR_W-1:0] word);
    instr_fields_t f;
    f.opcode = word[OPC_MSB:OPC_LSB];
    f.a      = word[FA_MSB:FA_LSB];
    f.b      = word[FB_MSB:FB_LSB];
    f.c      = word[FC_MSB:FC_LSB];
    return f;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Issue channel between the fetch unit (master) and the execute stage (slave).
interface fetch_unit_if #(
  parameter int AW = 3
);

  logic          issue_valid;
  logic          issue_ready;
  logic [2:0]    issue_opcode;
  logic [2:0]    issue_a;
  logic [2:0]    issue_b;
  logic [2:0]    issue_c;
  logic [AW-1:0] issue_pc;

  modport master (
    output issue_valid,
    output issue_opcode,
    output issue_a,
    output issue_b,
    output issue_c,
    output issue_pc,
    input  issue_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_opcode,
    input  issue_a,
    input  issue_b,
    input  issue_c,
    input  issue_pc,
    output issue_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory
// combinationally, resolves JMP/HALT locally and issues everything else.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int AW = 3,
  parameter int IW = INSTR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [AW-1:0]     imem_index,
  input  logic [IW-1:0]     imem_data,
  input  logic              br_taken,
  input  logic [AW-1:0]     br_target,
  fetch_unit_if.master      issue,
  output logic [AW-1:0]     pc,
  output logic              halted
);

  fetch_state_t  state;
  instr_fields_t fields;
  logic          valid_q;
  logic [2:0]    opcode_q;
  logic [2:0]    a_q;
  logic [2:0]    b_q;
  logic [2:0]    c_q;
  logic [AW-1:0] ipc_q;
  logic          accept;
  logic          fe;

  assign imem_index = pc;
  assign fields     = instr_fields(imem_data);
  assign accept     = valid_q && issue.issue_ready;
  // A new word may only be captured when the issue slot is free or draining now.
  assign fe         = (state == RUN) && run && (!valid_q || issue.issue_ready) && !br_taken;

  assign issue.issue_valid  = valid_q;
  assign issue.issue_opcode = opcode_q;
  assign issue.issue_a      = a_q;
  assign issue.issue_b      = b_q;
  assign issue.issue_c      = c_q;
  assign issue.issue_pc     = ipc_q;

  // Control FSM, PC and issue register share one block so priorities stay explicit:
  // redirect beats JMP/HALT, which beat a normal issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= '0;
      halted   <= 1'b0;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      ipc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) valid_q <= 1'b0;
          if (run) state <= RUN;
        end
        RUN: begin
          if (!run && !valid_q) state <= IDLE;
          if (br_taken) begin
            pc      <= br_target;
            valid_q <= 1'b0;
          end else if (fe) begin
            case (fields.opcode)
              OP_JMP: begin
                pc <= AW'(fields.c);
                if (accept) valid_q <= 1'b0;
              end
              OP_HALT: begin
                state  <= HALT;
                halted <= 1'b1;
                if (accept) valid_q <= 1'b0;
              end
              default: begin
                opcode_q <= fields.opcode;
                a_q      <= fields.a;
                b_q      <= fields.b;
                c_q      <= fields.c;
                ipc_q    <= pc;
                valid_q  <= 1'b1;
                pc       <= pc + AW'(1);
              end
            endcase
          end else if (accept) begin
            valid_q <= 1'b0;
          end
        end
        HALT: begin
          if (accept) valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        br_taken;
  logic [2:0]  br_target;
  logic [2:0]  imem_index;
  logic [11:0] imem_data;
  logic [2:0]  pc;
  logic        halted;
  logic [11:0] mem [8];

  int          compared = 0;
  int          mismatched = 0;
  int          dut_accepted [8];

  int          m_state;
  logic [2:0]  m_pc;
  logic [2:0]  m_ipc;
  logic [11:0] m_word;
  logic        m_valid;
  logic        m_halted;

  fetch_unit_if #(.AW(3)) issue_bus ();

  assign imem_data = mem[imem_index];

  fetch_unit #(.AW(3), .IW(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .imem_index (imem_index),
    .imem_data  (imem_data),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .issue      (issue_bus.master),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("issue_valid", 16'(issue_bus.issue_valid), 16'(m_valid));
    check("pc", 16'(pc), 16'(m_pc));
    check("imem_index", 16'(imem_index), 16'(m_pc));
    check("halted", 16'(halted), 16'(m_halted));
    if (m_valid) begin
      check("issue_pc", 16'(issue_bus.issue_pc), 16'(m_ipc));
      check("issue_opcode", 16'(issue_bus.issue_opcode), 16'(m_word[11:9]));
      check("issue_a", 16'(issue_bus.issue_a), 16'(m_word[8:6]));
      check("issue_b", 16'(issue_bus.issue_b), 16'(m_word[5:3]));
      check("issue_c", 16'(issue_bus.issue_c), 16'(m_word[2:0]));
    end
  endtask

  task automatic model_reset();
    m_state  = M_IDLE;
    m_pc     = '0;
    m_ipc    = '0;
    m_word   = '0;
    m_valid  = 1'b0;
    m_halted = 1'b0;
  endtask

  // One clock of the fetch rules, evaluated from the inputs about to be sampled.
  task automatic model_step(input logic r, input logic rdy, input logic br, input logic [2:0] tgt);
    logic        acc;
    logic        to_idle;
    logic [11:0] w;
    acc = m_valid && rdy;
    w   = mem[m_pc];
    case (m_state)
      M_IDLE: begin
        if (acc) m_valid = 1'b0;
        if (r) m_state = M_RUN;
      end
      M_RUN: begin
        to_idle = !r && !m_valid;
        if (br) begin
          m_pc    = tgt;
          m_valid = 1'b0;
        end else if (r && (!m_valid || rdy)) begin
          if (w[11:9] == 3'd6) begin
            m_pc = w[2:0];
            if (acc) m_valid = 1'b0;
          end else if (w[11:9] == 3'd7) begin
            m_state  = M_HALT;
            m_halted = 1'b1;
            if (acc) m_valid = 1'b0;
          end else begin
            m_word  = w;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = 3'((int'(m_pc) + 1) % 8);
          end
        end else if (acc) begin
          m_valid = 1'b0;
        end
        if (to_idle) m_state = M_IDLE;
      end
      default: begin
        if (acc) m_valid = 1'b0;
      end
    endcase
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy, input logic br,
                                input logic [2:0] tgt, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      run                   = r;
      issue_bus.issue_ready = rdy;
      br_taken              = br;
      br_target             = tgt;
      if (issue_bus.issue_valid && rdy && !br) dut_accepted[issue_bus.issue_pc]++;
      model_step(r, rdy, br, tgt);
      @(posedge clk);
      #1;
      check_output();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                 = 1'b0;
    run                   = 1'b0;
    issue_bus.issue_ready = 1'b0;
    br_taken              = 1'b0;
    br_target             = '0;
    model_reset();
    for (int i = 0; i < 8; i++) dut_accepted[i] = 0;
    #1;
    check_output();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic fill_alu();
    for (int i = 0; i < 8; i++) mem[i] = 12'b001_000_000_000 | 12'(i);
  endtask

  initial begin
    reset                 = 1'b0;
    run                   = 1'b0;
    issue_bus.issue_ready = 1'b0;
    br_taken              = 1'b0;
    br_target             = '0;
    fill_alu();
    model_reset();

    // Reset state and straight-line issue
    #12;
    check_output();
    check("reset_issue_pc", 16'(issue_bus.issue_pc), 16'd0);
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1);
    check("valid_low_cycle1", 16'(issue_bus.issue_valid), 16'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1);
    check("valid_high_cycle2", 16'(issue_bus.issue_valid), 16'd1);
    check("first_issue_pc", 16'(issue_bus.issue_pc), 16'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 8);

    // Jump loop: address 3 jumps back to 1
    fill_alu();
    mem[3] = 12'b110_000_000_001;
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 14);
    check("jmp_target_never_issued", 16'(dut_accepted[3]), 16'd0);
    check("jmp_loop_repeats", 16'(dut_accepted[1] >= 2), 16'd1);

    // Back-pressure holds the instruction from address 2
    fill_alu();
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 4);
    apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 4);
    check("stall_issue_pc", 16'(issue_bus.issue_pc), 16'd2);
    check("stall_pc", 16'(pc), 16'd3);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 3);

    // Redirect while address 4 is held
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 6);
    apply_stimulus(1'b1, 1'b0, 1'b0, 3'd0, 1);
    check("held_before_branch", 16'(issue_bus.issue_pc), 16'd4);
    apply_stimulus(1'b1, 1'b0, 1'b1, 3'd5, 1);
    check("branch_flush", 16'(issue_bus.issue_valid), 16'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1);
    check("branch_target_issued", 16'(issue_bus.issue_pc), 16'd5);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 1);
    check("addr4_never_accepted", 16'(dut_accepted[4]), 16'd0);

    // HALT at address 7, then async reset mid-cycle
    fill_alu();
    mem[7] = 12'b111_000_000_000;
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 12);
    check("halt_sticky", 16'(halted), 16'd1);
    check("halt_pc", 16'(pc), 16'd7);
    check("halt_last_issue", 16'(dut_accepted[6]), 16'd1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 3'd2, 2);
    check("halt_ignores_branch", 16'(pc), 16'd7);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output();
    check("async_reset_halted", 16'(halted), 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Wrap 7 -> 0, then drop run, drain and resume
    fill_alu();
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 11);
    apply_stimulus(1'b0, 1'b0, 1'b0, 3'd0, 2);
    apply_stimulus(1'b0, 1'b1, 1'b0, 3'd0, 3);
    check("run_drop_drained", 16'(issue_bus.issue_valid), 16'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 3'd0, 4);

    // Randomized programs and handshake traffic
    for (int ep = 0; ep < 30; ep++) begin
      for (int i = 0; i < 8; i++) begin
        int sel;
        sel = int'($urandom_range(0, 15));
        if (sel < 12)       mem[i] = {3'($urandom_range(0, 5)), 9'($urandom)};
        else if (sel < 15)  mem[i] = {3'b110, 9'($urandom)};
        else                mem[i] = {3'b111, 9'($urandom)};
      end
      do_reset();
      for (int c = 0; c < 60; c++) begin
        apply_stimulus(($urandom % 8) != 0, ($urandom % 4) != 0,
                       ($urandom % 10) == 0, 3'($urandom), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
